ksa_swap_engine: RTL and testbench
==================================

# ksa_swap_engine

Parametrised RC4 key-scheduling swap engine: performs the second KSA pass over an already-initialised state array S (S[k]=k written by the fill loop). It walks i = 0..N-1, computes j = j + S[i] + key[i mod key_len], and swaps S[i] and S[j] through a single-port synchronous RAM. Array size, key length and RAM read latency are parameters; a start/busy/done handshake supports restart without reset. It sits between the S-array init loop and the PRGA/decrypt stage and owns the RAM port while busy.

## Interface
- ADDR_W, 8: S-array address width; N = 2^ADDR_W entries of 8 bits.
- KEY_BYTES_MAX, 3: maximum key length in bytes.
- RD_LAT, 2: RAM read latency; rddata is sampled RD_LAT+1 rising edges after the edge that registers addr.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE or DONE.
- key  in  8*KEY_BYTES_MAX  key; byte k = key[8*(KEY_BYTES_MAX-k)-1 -: 8], so byte 0 is the MSB byte.
- key_len  in  $clog2(KEY_BYTES_MAX+1)  active key bytes; 0 or >KEY_BYTES_MAX is treated as KEY_BYTES_MAX.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  high in DONE; held until the next start is accepted.
- addr  out  ADDR_W  RAM address, registered.
- rddata  in  8  RAM read data.
- wrdata  out  8  RAM write data, registered.
- wren  out  1  RAM write enable, registered.

## Operation
- States: IDLE, RD_I, WAIT_I (RD_LAT cycles), SAVE_I, RD_J, WAIT_J (RD_LAT cycles), SAVE_J, WR_J, WR_I, DONE.
- IDLE/DONE with start=1: latch key and effective key_len, clear i, j and key index kidx, set done=0 and busy=1, go to RD_I. In DONE with start=0, stay in DONE.
- RD_I: addr<=i, wren<=0. WAIT_I: count RD_LAT cycles. SAVE_I: si<=rddata; j<=j+rddata+keybyte[kidx].
- RD_J: addr<=j, wren<=0. WAIT_J: count RD_LAT cycles. SAVE_J: sj<=rddata.
- WR_J: addr<=j, wrdata<=si, wren<=1. WR_I: addr<=i, wrdata<=sj, wren<=1.
- Leaving WR_I: if i==N-1, go to DONE with wren<=0, addr<=0, busy<=0, done<=1. Otherwise i<=i+1, kidx<=(kidx==key_len-1)?0:kidx+1, go to RD_I.
- Arithmetic: j and i are ADDR_W bits. j wraps mod N; only the low ADDR_W bits of the 8-bit sum are kept when ADDR_W<8. kidx is a wrap counter (no divider). The key is sampled once at start; later key changes are ignored.
- i==j: both writes target the same address with the same data. This is legal and needs no special case.
- start while busy: ignored.
- rst mid-operation: all registers clear immediately and the block returns to IDLE. RAM contents are left partially permuted; the controller must re-run the init loop.
- Reset values: addr=0, wrdata=0, wren=0, busy=0, done=0, state=IDLE.

## Timing
- Per iteration: 6+2*RD_LAT cycles, with exactly two write cycles (wren=1), WR_J then WR_I, back-to-back.
- Start-to-done: done rises N*(6+2*RD_LAT) edges after the edge that accepts start. For N=256 and RD_LAT=2 this is 2560 cycles.
- No write occurs while the block is in IDLE or DONE. wren is never high in the same cycle as a read address.
- Restart from DONE: done falls on the accepting edge, and the first RD_I address appears on the next cycle.

## Test plan
- Identity S (N=256, RD_LAT=2), key_len=3, key=24'h010203 -> first writes are (addr 1, data 0x00) then (addr 0, data 0x01). The final RAM contents match a software KSA model byte-for-byte.
- Same run, cycle count -> busy is high for exactly 2560 cycles, done rises at cycle 2560 after start, and exactly 512 write cycles are observed.
- key_len=1, key=24'hAB0000 versus key_len=3, key=24'hABABAB, each from identity S -> identical final RAM contents. key_len=0 behaves the same as key_len=3.
- Identity S, key byte0=0x00 -> iteration 0 has i=j=0, and both writes are (addr 0, data 0x00). The run continues correctly.
- rst pulsed at cycle 1000 -> busy, done, wren and addr read 0 immediately, and no writes occur until a new start. Re-init plus restart completes in 2560 cycles with correct contents. A start pulse at cycle 500 of a run is ignored, and the cycle count is unchanged.
- ADDR_W=4, RD_LAT=1, KEY_BYTES_MAX=5, key_len=5 -> done after 16*8=128 cycles. j wraps mod 16, and the result matches a model with N=16.

Source files
------------

// File: rtl/ksa_swap_if.sv
// Start/busy/done handshake plus the single-port S-array RAM bus of the KSA swap engine.
// The master side is the host together with the RAM; the slave side is the engine.
interface ksa_swap_if #(
    parameter int ADDR_W        = 8,
    parameter int KEY_BYTES_MAX = 3
);
    localparam int KL_W = $clog2(KEY_BYTES_MAX + 1);

    logic                       start;
    logic [8*KEY_BYTES_MAX-1:0] key;
    logic [KL_W-1:0]            key_len;
    logic                       busy;
    logic                       done;
    logic [ADDR_W-1:0]          addr;
    logic [7:0]                 rddata;
    logic [7:0]                 wrdata;
    logic                       wren;

    modport master (
        output start, key, key_len, rddata,
        input  busy, done, addr, wrdata, wren
    );

    modport slave (
        input  start, key, key_len, rddata,
        output busy, done, addr, wrdata, wren
    );
endinterface

// File: rtl/ksa_swap_engine.sv
// RC4 KSA second pass: walks i over the S array and swaps S[i]/S[j] through a
// single-port synchronous RAM, with j = j + S[i] + key[i mod key_len].
module ksa_swap_engine #(
    parameter int ADDR_W        = 8,
    parameter int KEY_BYTES_MAX = 3,
    parameter int RD_LAT        = 2
) (
    input  logic      clk,
    input  logic      rst,
    ksa_swap_if.slave bus
);
    localparam int KL_W = $clog2(KEY_BYTES_MAX + 1);
    localparam int WC_W = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        IDLE, RD_I, WAIT_I, SAVE_I, RD_J, WAIT_J, SAVE_J, WR_J, WR_I, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [KL_W-1:0]   kidx;
    logic [KL_W-1:0]   klast;
    logic [7:0]        key_b [KEY_BYTES_MAX];
    logic [7:0]        si;
    logic [WC_W-1:0]   wcnt;
    logic [KL_W-1:0]   klen_eff;
    logic [7:0]        jsum;

    always_comb begin
        klen_eff = bus.key_len;
        if (bus.key_len == '0 || bus.key_len > KL_W'(KEY_BYTES_MAX))
            klen_eff = KL_W'(KEY_BYTES_MAX);
    end

    // 8-bit sum; only the low ADDR_W bits survive into j, giving the mod-N wrap.
    assign jsum = 8'(j) + bus.rddata + key_b[kidx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            kidx       <= '0;
            klast      <= '0;
            si         <= '0;
            wcnt       <= '0;
            bus.addr   <= '0;
            bus.wrdata <= '0;
            bus.wren   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            for (int k = 0; k < KEY_BYTES_MAX; k++) key_b[k] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        for (int k = 0; k < KEY_BYTES_MAX; k++)
                            key_b[k] <= bus.key[8*(KEY_BYTES_MAX-k)-1 -: 8];
                        klast    <= klen_eff - KL_W'(1);
                        i        <= '0;
                        j        <= '0;
                        kidx     <= '0;
                        bus.done <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= RD_I;
                    end
                end
                RD_I: begin
                    bus.addr <= i;
                    bus.wren <= 1'b0;
                    wcnt     <= '0;
                    state    <= WAIT_I;
                end
                WAIT_I: begin
                    if (wcnt == WC_W'(RD_LAT - 1)) state <= SAVE_I;
                    else                           wcnt  <= wcnt + WC_W'(1);
                end
                SAVE_I: begin
                    si    <= bus.rddata;
                    j     <= jsum[ADDR_W-1:0];
                    state <= RD_J;
                end
                RD_J: begin
                    bus.addr <= j;
                    bus.wren <= 1'b0;
                    wcnt     <= '0;
                    state    <= WAIT_J;
                end
                WAIT_J: begin
                    if (wcnt == WC_W'(RD_LAT - 1)) state <= SAVE_J;
                    else                           wcnt  <= wcnt + WC_W'(1);
                end
                // Write strobes are registered, so each write is set up one state early:
                // S[j] <= si is on the bus during WR_J, S[i] <= S[j] during WR_I.
                SAVE_J: begin
                    bus.addr   <= j;
                    bus.wrdata <= si;
                    bus.wren   <= 1'b1;
                    state      <= WR_J;
                end
                WR_J: begin
                    bus.addr   <= i;
                    bus.wrdata <= bus.rddata;
                    bus.wren   <= 1'b1;
                    state      <= WR_I;
                end
                WR_I: begin
                    bus.wren <= 1'b0;
                    if (i == '1) begin
                        bus.addr <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        i     <= i + ADDR_W'(1);
                        kidx  <= (kidx == klast) ? '0 : kidx + KL_W'(1);
                        state <= RD_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ksa_swap_engine.sv
// Directed bench: two engine configurations, each with a behavioural latency-matched RAM,
// compared against a software KSA model and hand-computed cycle and write counts.
module tb_ksa_swap_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ksa_swap_if #(.ADDR_W(8), .KEY_BYTES_MAX(3)) bus_a ();
    ksa_swap_if #(.ADDR_W(4), .KEY_BYTES_MAX(5)) bus_b ();

    ksa_swap_engine #(.ADDR_W(8), .KEY_BYTES_MAX(3), .RD_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    ksa_swap_engine #(.ADDR_W(4), .KEY_BYTES_MAX(5), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem_a [256];
    logic [7:0] pipe_a [2];
    logic [7:0] mem_b [16];
    logic [7:0] pipe_b;
    logic       fill = 1'b0;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;
    int         wr_a = 0, busy_a = 0, wr_b = 0, busy_b = 0, idle_wr = 0;
    logic [7:0] log_addr [2];
    logic [7:0] log_data [2];

    assign bus_a.rddata = pipe_a[1];
    assign bus_b.rddata = pipe_b;

    // RAM A: two-stage read pipeline (RD_LAT=2) plus write/busy bookkeeping.
    always @(posedge clk) begin
        if (fill) for (int k = 0; k < 256; k++) mem_a[k] <= 8'(k);
        else if (bus_a.wren) mem_a[bus_a.addr] <= bus_a.wrdata;
        pipe_a[0] <= mem_a[bus_a.addr];
        pipe_a[1] <= pipe_a[0];
        if (clr_a) begin
            wr_a   <= 0;
            busy_a <= 0;
        end else begin
            if (bus_a.wren) begin
                if (wr_a < 2) begin
                    log_addr[wr_a[0]] <= bus_a.addr;
                    log_data[wr_a[0]] <= bus_a.wrdata;
                end
                wr_a <= wr_a + 1;
            end
            if (bus_a.busy) busy_a <= busy_a + 1;
        end
        if ((bus_a.wren && !bus_a.busy) || (bus_b.wren && !bus_b.busy)) idle_wr <= idle_wr + 1;
    end

    // RAM B: single-stage read pipeline (RD_LAT=1).
    always @(posedge clk) begin
        if (fill) for (int k = 0; k < 16; k++) mem_b[k] <= 8'(k);
        else if (bus_b.wren) mem_b[bus_b.addr] <= bus_b.wrdata;
        pipe_b <= mem_b[bus_b.addr];
        if (clr_b) begin
            wr_b   <= 0;
            busy_b <= 0;
        end else begin
            if (bus_b.wren) wr_b <= wr_b + 1;
            if (bus_b.busy) busy_b <= busy_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    logic [7:0] exp_s [256];
    logic [7:0] saved [256];
    logic [7:0] mkey [5];

    task automatic ksa_model(input int n, input int kl);
        int jj;
        logic [7:0] t;
        jj = 0;
        for (int k = 0; k < n; k++) exp_s[k] = 8'(k);
        for (int ii = 0; ii < n; ii++) begin
            jj = (jj + int'(exp_s[ii]) + int'(mkey[ii % kl])) % n;
            t = exp_s[ii];
            exp_s[ii] = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    task automatic cmp_a(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem_a[k] !== exp_s[k]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic fill_mem();
        @(negedge clk); fill = 1'b1;
        @(negedge clk); fill = 1'b0;
    endtask

    task automatic run_a(input logic [23:0] k, input logic [1:0] kl, input int rst_at,
                         input int pulse_at, output int cyc);
        int w0;
        @(negedge clk);
        bus_a.key = k; bus_a.key_len = kl; bus_a.start = 1'b1; clr_a = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0; clr_a = 1'b0;
        bus_a.key = ~k; bus_a.key_len = 2'd1;
        chk("accept_busy", bus_a.busy, 1);
        chk("accept_done", bus_a.done, 0);
        cyc = 0;
        while (!bus_a.done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            bus_a.start = (cyc == pulse_at);
            if (cyc == rst_at) begin
                rst = 1'b1; #1;
                chk("rst_busy", bus_a.busy, 0);
                chk("rst_done", bus_a.done, 0);
                chk("rst_wren", bus_a.wren, 0);
                chk("rst_addr", bus_a.addr, 0);
                @(negedge clk); rst = 1'b0;
                w0 = wr_a;
                repeat (20) @(posedge clk);
                #1 chk("no_wr_after_rst", wr_a - w0, 0);
                chk("idle_after_rst", bus_a.busy, 0);
                break;
            end
        end
        bus_a.start = 1'b0;
    endtask

    task automatic run_b(input logic [39:0] k, input logic [2:0] kl, output int cyc);
        @(negedge clk);
        bus_b.key = k; bus_b.key_len = kl; bus_b.start = 1'b1; clr_b = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0; clr_b = 1'b0;
        cyc = 0;
        while (!bus_b.done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.key = '0; bus_a.key_len = '0;
        bus_b.start = 1'b0; bus_b.key = '0; bus_b.key_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", bus_a.addr, 0);
        chk("reset_wrdata", bus_a.wrdata, 0);
        chk("reset_wren", bus_a.wren, 0);
        chk("reset_busy", bus_a.busy, 0);
        chk("reset_done", bus_a.done, 0);
        @(negedge clk); rst = 1'b0;

        // Reference run: key 01 02 03
        fill_mem();
        mkey = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        run_a(24'h010203, 2'd3, 0, 0, cyc);
        chk("cycles_k3", cyc, 2560);
        chk("busy_cycles_k3", busy_a, 2560);
        chk("writes_k3", wr_a, 512);
        chk("wr0_addr", log_addr[0], 8'h01);
        chk("wr0_data", log_data[0], 8'h00);
        chk("wr1_addr", log_addr[1], 8'h00);
        chk("wr1_data", log_data[1], 8'h01);
        ksa_model(256, 3);
        cmp_a("ram_k3");
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", bus_a.done, 1);
        chk("done_wren", bus_a.wren, 0);

        // key_len=1 versus repeated key bytes
        fill_mem();
        run_a(24'hAB0000, 2'd1, 0, 0, cyc);
        for (int k = 0; k < 256; k++) saved[k] = mem_a[k];
        mkey = '{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00};
        ksa_model(256, 1);
        cmp_a("ram_kl1");
        fill_mem();
        run_a(24'hABABAB, 2'd3, 0, 0, cyc);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem_a[k] !== saved[k]) bad++;
        chk("kl1_vs_kl3", bad, 0);

        // key_len=0 acts as 3
        fill_mem();
        mkey = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        run_a(24'h010203, 2'd0, 0, 0, cyc);
        chk("cycles_kl0", cyc, 2560);
        ksa_model(256, 3);
        cmp_a("ram_kl0");

        // key byte0 = 0: first swap is i=j=0
        fill_mem();
        mkey = '{8'h00, 8'h07, 8'h09, 8'h00, 8'h00};
        run_a(24'h000709, 2'd3, 0, 0, cyc);
        chk("ieqj_wr0_addr", log_addr[0], 8'h00);
        chk("ieqj_wr0_data", log_data[0], 8'h00);
        chk("ieqj_wr1_addr", log_addr[1], 8'h00);
        chk("ieqj_wr1_data", log_data[1], 8'h00);
        ksa_model(256, 3);
        cmp_a("ram_ieqj");

        // Reset mid-run, then re-init and restart with an ignored start pulse
        fill_mem();
        run_a(24'h010203, 2'd3, 1000, 0, cyc);
        fill_mem();
        mkey = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        run_a(24'h010203, 2'd3, 0, 500, cyc);
        chk("cycles_restart", cyc, 2560);
        chk("busy_restart", busy_a, 2560);
        chk("writes_restart", wr_a, 512);
        ksa_model(256, 3);
        cmp_a("ram_restart");

        // Small configuration: N=16, RD_LAT=1, 5-byte key
        fill_mem();
        mkey = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4};
        run_b(40'hF0E1D2C3B4, 3'd5, cyc);
        chk("cycles_n16", cyc, 128);
        chk("busy_n16", busy_b, 128);
        chk("writes_n16", wr_b, 32);
        ksa_model(16, 5);
        bad = 0;
        for (int k = 0; k < 16; k++) if (mem_b[k] !== exp_s[k]) bad++;
        chk("ram_n16", bad, 0);

        chk("writes_outside_busy", idle_wr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
